// File: rtl/shift_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
// Shared definitions for the shift_seq universal shift register:
//   - MODE_* : shift-mode encodings carried on the 3-bit `mode` input
//   - state_t: control FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE)
//   - mode_legal(): true for modes that perform a shift
// Build option: SHIFT_SEQ_SRA_EN makes MODE_SRA legal; otherwise it is reserved.
// -----------------------------------------------------------------------------
package shift_seq_pkg;

    localparam logic [2:0] MODE_SLL = 3'd0;
    localparam logic [2:0] MODE_SRL = 3'd1;
    localparam logic [2:0] MODE_ROL = 3'd2;
    localparam logic [2:0] MODE_ROR = 3'd3;
    localparam logic [2:0] MODE_SRA = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic mode_legal(input logic [2:0] mode);
`ifdef SHIFT_SEQ_SRA_EN
        return (mode <= MODE_SRA);
`else
        return (mode <= MODE_ROR);
`endif
    endfunction

endpackage

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Combinational shifter: moves data_i by k_i bit positions (1..STEP) in the
// given mode and reports the last bit to leave the word (the k-th exiting bit,
// or the k-th wrapped bit for rotates).
// Ports:
//   data_i  [WIDTH-1:0] word before the shift
//   mode_i  [2:0]       MODE_* encoding
//   fill_i              fill bit for SLL/SRL vacated positions
//   k_i     [KW-1:0]    shift amount, 1..STEP
//   data_o  [WIDTH-1:0] word after the shift
//   exit_o              last bit shifted/rotated out
// Build option: SHIFT_SEQ_SRA_EN adds the arithmetic right shift.
// -----------------------------------------------------------------------------
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int KW    = 4
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [2:0]       mode_i,
    input  logic             fill_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] data_o,
    output logic             exit_o
);

    logic [WIDTH-1:0] word;
    logic             bit_out;

    // Unrolled chain of single-bit steps; step i is active only when i < k_i.
    // NOTE: blocking assignments here are intentional -- each step reads the
    // word produced by the previous step within the same evaluation.
    always_comb begin
        word    = data_i;
        bit_out = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(k_i)) begin
                case (mode_i)
                    MODE_SLL: begin
                        bit_out = word[WIDTH-1];
                        word    = {word[WIDTH-2:0], fill_i};
                    end
                    MODE_SRL: begin
                        bit_out = word[0];
                        word    = {fill_i, word[WIDTH-1:1]};
                    end
                    MODE_ROL: begin
                        bit_out = word[WIDTH-1];
                        word    = {word[WIDTH-2:0], word[WIDTH-1]};
                    end
                    MODE_ROR: begin
                        bit_out = word[0];
                        word    = {word[0], word[WIDTH-1:1]};
                    end
`ifdef SHIFT_SEQ_SRA_EN
                    // The MSB never changes under SRA, so refilling from the
                    // current word equals filling from the pre-shift MSB.
                    MODE_SRA: begin
                        bit_out = word[0];
                        word    = {word[WIDTH-1], word[WIDTH-1:1]};
                    end
`endif
                    default: begin
                        word    = word;
                        bit_out = bit_out;
                    end
                endcase
            end
        end
        data_o = word;
        exit_o = bit_out;
    end

endmodule

// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq
// Multi-cycle universal shift register with parallel load, five shift modes,
// a programmable shift amount consumed up to STEP bits per cycle, serial
// output and a start/busy/done handshake.
// Parameters: WIDTH (>=2), STEP (1..WIDTH), AMT_W (shift-amount width).
// Ports:
//   clk                  rising-edge clock
//   arstn                synchronous active-low reset
//   load, load_data      parallel load (accepted in idle only; wins over start)
//   start, mode, amt     shift command; mode/amt latched at start
//   s_in                 serial fill bit, sampled on every shift edge
//   out                  register contents
//   s_out                last bit shifted or rotated out
//   busy                 high while shifting
//   done                 one-cycle completion pulse
// Build option: SHIFT_SEQ_SRA_EN enables mode 4 (SRA); otherwise mode 4 is
// reserved and completes immediately with `out` unchanged.
// -----------------------------------------------------------------------------
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic             s_in,
    output logic [WIDTH-1:0] out,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             s_out_q, s_out_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;

    logic [AMT_W-1:0] k;
    logic [WIDTH-1:0] step_data;
    logic             step_exit;

    // Bits consumed on this edge: the full step, or whatever remains.
    assign k = (rem_q > STEP_A) ? STEP_A : rem_q;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (AMT_W)
    ) u_step (
        .data_i (out_q),
        .mode_i (mode_q),
        .fill_i (s_in),
        .k_i    (k),
        .data_o (step_data),
        .exit_o (step_exit)
    );

    // NOTE: every signal gets its hold value first so no path through the case
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        s_out_d = s_out_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    out_d = load_data;
                end else if (start) begin
                    if (mode_legal(mode) && (amt != '0)) begin
                        state_d = ST_SHIFT;
                        rem_d   = amt;
                        mode_d  = mode;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                out_d   = step_data;
                s_out_d = step_exit;
                rem_d   = rem_q - k;
                if (rem_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: reset is sampled on the clock edge, so it lives inside the clocked
    // branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            s_out_q <= 1'b0;
            rem_q   <= '0;
            mode_q  <= MODE_SLL;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            s_out_q <= s_out_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign out   = out_q;
    assign s_out = s_out_q;
    assign busy  = (state_q == ST_SHIFT);
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_seq
// Self-checking bench for shift_seq (WIDTH=8). Two instances share all inputs:
// index 0 runs STEP=1, index 1 runs STEP=3. Directed table plus hand-written
// corner sequences plus random commands checked against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_shift_seq;
    import shift_seq_pkg::*;

`ifdef SHIFT_SEQ_SRA_EN
    localparam bit SRA_EN = 1'b1;
`else
    localparam bit SRA_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       arstn;
    logic       load;
    logic [7:0] load_data;
    logic       start;
    logic [2:0] mode;
    logic [3:0] amt;
    logic       s_in;

    logic [7:0] out_a, out_b;
    logic       so_a, so_b, busy_a, busy_b, done_a, done_b;

    always #5 clk = ~clk;

    shift_seq #(.WIDTH(8), .STEP(1)) dut_a (
        .clk(clk), .arstn(arstn), .load(load), .load_data(load_data),
        .start(start), .mode(mode), .amt(amt), .s_in(s_in),
        .out(out_a), .s_out(so_a), .busy(busy_a), .done(done_a)
    );

    shift_seq #(.WIDTH(8), .STEP(3)) dut_b (
        .clk(clk), .arstn(arstn), .load(load), .load_data(load_data),
        .start(start), .mode(mode), .amt(amt), .s_in(s_in),
        .out(out_b), .s_out(so_b), .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int errors = 0;

    // Per-instance expected trace: exp_seq[i][j] / exp_so[i][j] after shift j.
    logic [7:0] exp_seq [2][17];
    logic       exp_so  [2][17];
    int         exp_n   [2];
    logic       cur_so  [2];
    int         busy_cnt [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: whole-word arithmetic per cycle, k = min(step, remaining).
    task automatic model(input int inst, input int step, input logic [7:0] init,
                         input logic init_s, input logic [2:0] md, input int amount,
                         input logic fill);
        int v, s, rem, k, n;
        bit legal;
        v     = int'(init);
        s     = int'(init_s);
        legal = (md <= 3) || (md == 4 && SRA_EN);
        rem   = legal ? amount : 0;
        n     = 0;
        exp_seq[inst][0] = init;
        exp_so[inst][0]  = init_s;
        while (rem > 0) begin
            k = (rem < step) ? rem : step;
            case (md)
                3'd0: begin
                    s = (v >> (8 - k)) & 1;
                    v = ((v << k) | (fill ? ((1 << k) - 1) : 0)) & 255;
                end
                3'd1: begin
                    s = (v >> (k - 1)) & 1;
                    v = (v >> k) | (fill ? ((((1 << k) - 1) << (8 - k)) & 255) : 0);
                end
                3'd2: begin
                    v = ((v << k) | (v >> (8 - k))) & 255;
                    s = v & 1;
                end
                3'd3: begin
                    v = ((v >> k) | (v << (8 - k))) & 255;
                    s = (v >> 7) & 1;
                end
                default: begin
                    s = (v >> (k - 1)) & 1;
                    v = (v >> k) | (((v & 128) != 0) ? ((255 << (8 - k)) & 255) : 0);
                end
            endcase
            n++;
            rem -= k;
            exp_seq[inst][n] = v[7:0];
            exp_so[inst][n]  = s[0];
        end
        exp_n[inst] = n;
    endtask

    task automatic check_inst(input int inst, input int c);
        int j;
        j = (c < exp_n[inst]) ? c : exp_n[inst];
        if (inst == 0) begin
            check($sformatf("s1 out c%0d", c), 32'(out_a), 32'(exp_seq[0][j]));
            check($sformatf("s1 s_out c%0d", c), 32'(so_a), 32'(exp_so[0][j]));
            check($sformatf("s1 busy c%0d", c), 32'(busy_a), 32'(c < exp_n[0]));
            check($sformatf("s1 done c%0d", c), 32'(done_a), 32'(c == exp_n[0]));
            if (busy_a) busy_cnt[0]++;
        end else begin
            check($sformatf("s3 out c%0d", c), 32'(out_b), 32'(exp_seq[1][j]));
            check($sformatf("s3 s_out c%0d", c), 32'(so_b), 32'(exp_so[1][j]));
            check($sformatf("s3 busy c%0d", c), 32'(busy_b), 32'(c < exp_n[1]));
            check($sformatf("s3 done c%0d", c), 32'(done_b), 32'(c == exp_n[1]));
            if (busy_b) busy_cnt[1]++;
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        load      = 1'b1;
        load_data = v;
        @(negedge clk);
        load = 1'b0;
        check("load out s1", 32'(out_a), 32'(v));
        check("load out s3", 32'(out_b), 32'(v));
    endtask

    // Load lv, issue one command, and check both instances every cycle until
    // one cycle past the later done. With poke, start+load are re-asserted in
    // the first busy cycle and must be ignored.
    task automatic run_cmd(input logic [7:0] lv, input logic [2:0] md, input logic [3:0] a,
                           input logic fill, input bit poke);
        int maxn;
        do_load(lv);
        model(0, 1, lv, cur_so[0], md, int'(a), fill);
        model(1, 3, lv, cur_so[1], md, int'(a), fill);
        maxn = (exp_n[0] > exp_n[1]) ? exp_n[0] : exp_n[1];
        busy_cnt[0] = 0;
        busy_cnt[1] = 0;
        start = 1'b1;
        mode  = md;
        amt   = a;
        s_in  = fill;
        @(posedge clk);
        for (int c = 0; c <= maxn + 1; c++) begin
            @(negedge clk);
            check_inst(0, c);
            check_inst(1, c);
            if (c == 0) begin
                start     = poke;
                load      = poke;
                load_data = ~lv;
                mode      = MODE_SLL;
                amt       = 4'd1;
            end else begin
                start = 1'b0;
                load  = 1'b0;
            end
        end
        cur_so[0] = exp_so[0][exp_n[0]];
        cur_so[1] = exp_so[1][exp_n[1]];
    endtask

    typedef struct {
        logic [7:0] lv;
        logic [2:0] md;
        logic [3:0] a;
        logic       fill;
        bit         poke;
        logic [7:0] f1;
        logic       s1;
        int         n1;
        logic [7:0] f3;
        logic       s3;
        int         n3;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{8'hB4, MODE_ROL, 4'd3, 1'b0, 1'b1, 8'hA5, 1'b1, 3, 8'hA5, 1'b1, 1};
        tbl[1] = '{8'h01, MODE_SLL, 4'd7, 1'b1, 1'b0, 8'hFF, 1'b0, 7, 8'hFF, 1'b0, 3};
`ifdef SHIFT_SEQ_SRA_EN
        tbl[2] = '{8'h90, MODE_SRA, 4'd2, 1'b0, 1'b0, 8'hE4, 1'b0, 2, 8'hE4, 1'b0, 1};
`else
        tbl[2] = '{8'h90, MODE_SRA, 4'd2, 1'b0, 1'b0, 8'h90, 1'b0, 0, 8'h90, 1'b0, 0};
`endif
        tbl[3] = '{8'h3C, MODE_SLL, 4'd0, 1'b1, 1'b0, 8'h3C, 1'b0, 0, 8'h3C, 1'b0, 0};
        tbl[4] = '{8'h3C, 3'd6,     4'd3, 1'b1, 1'b0, 8'h3C, 1'b0, 0, 8'h3C, 1'b0, 0};
        tbl[5] = '{8'hA5, MODE_SRL, 4'd10, 1'b1, 1'b0, 8'hFF, 1'b1, 10, 8'hFF, 1'b1, 4};
        tbl[6] = '{8'h81, MODE_ROR, 4'd9, 1'b0, 1'b1, 8'hC0, 1'b1, 9, 8'hC0, 1'b1, 3};

        arstn     = 1'b0;
        load      = 1'b0;
        load_data = '0;
        start     = 1'b0;
        mode      = '0;
        amt       = '0;
        s_in      = 1'b0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst out s1", 32'(out_a), 32'h00);
        check("rst s_out s1", 32'(so_a), 32'h0);
        check("rst busy s1", 32'(busy_a), 32'h0);
        check("rst done s1", 32'(done_a), 32'h0);
        check("rst out s3", 32'(out_b), 32'h00);
        check("rst done s3", 32'(done_b), 32'h0);
        arstn     = 1'b1;
        cur_so[0] = 1'b0;
        cur_so[1] = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_cmd(tbl[i].lv, tbl[i].md, tbl[i].a, tbl[i].fill, tbl[i].poke);
            check($sformatf("tbl%0d final s1", i), 32'(out_a), 32'(tbl[i].f1));
            check($sformatf("tbl%0d s_out s1", i), 32'(so_a), 32'(tbl[i].s1));
            check($sformatf("tbl%0d busy cycles s1", i), 32'(busy_cnt[0]), 32'(tbl[i].n1));
            check($sformatf("tbl%0d final s3", i), 32'(out_b), 32'(tbl[i].f3));
            check($sformatf("tbl%0d s_out s3", i), 32'(so_b), 32'(tbl[i].s3));
            check($sformatf("tbl%0d busy cycles s3", i), 32'(busy_cnt[1]), 32'(tbl[i].n3));
        end

        // Load together with start: load wins, no done
        @(negedge clk);
        load      = 1'b1;
        start     = 1'b1;
        load_data = 8'h5A;
        mode      = MODE_ROL;
        amt       = 4'd3;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        check("ld+st out s1", 32'(out_a), 32'h5A);
        check("ld+st out s3", 32'(out_b), 32'h5A);
        for (int c = 0; c < 3; c++) begin
            check("ld+st done s1", 32'(done_a), 32'h0);
            check("ld+st busy s1", 32'(busy_a), 32'h0);
            check("ld+st done s3", 32'(done_b), 32'h0);
            @(negedge clk);
        end

        // Reset after the 2nd shift edge of ROR amt=6
        do_load(8'h3C);
        start = 1'b1;
        mode  = MODE_ROR;
        amt   = 4'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("mid s1 before rst", 32'(out_a), 32'h0F);
        arstn = 1'b0;
        @(negedge clk);
        check("abort out s1", 32'(out_a), 32'h00);
        check("abort s_out s1", 32'(so_a), 32'h0);
        check("abort busy s1", 32'(busy_a), 32'h0);
        check("abort done s1", 32'(done_a), 32'h0);
        check("abort out s3", 32'(out_b), 32'h00);
        check("abort done s3", 32'(done_b), 32'h0);
        arstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post-abort done s1", 32'(done_a), 32'h0);
            check("post-abort busy s1", 32'(busy_a), 32'h0);
            check("post-abort out s1", 32'(out_a), 32'h00);
        end
        cur_so[0] = 1'b0;
        cur_so[1] = 1'b0;

        // Random commands against the model
        for (int r = 0; r < 40; r++) begin
            logic [7:0] lv;
            logic [2:0] md;
            logic [3:0] a;
            logic       fill;
            bit         pk;
            lv   = 8'($urandom_range(0, 255));
            md   = 3'($urandom_range(0, 7));
            a    = 4'($urandom_range(0, 15));
            fill = 1'($urandom_range(0, 1));
            pk   = ((md <= 3 || (md == 4 && SRA_EN)) && a != 0) ? bit'($urandom_range(0, 1)) : 1'b0;
            run_cmd(lv, md, a, fill, pk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
